// File: rtl/snake_pkg.sv
// Shared snake-game constants and types: grid geometry, apple FSM states and the LFSR step function.
package snake_pkg;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int X_W    = 5;
  localparam int Y_W    = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RESPAWN = 3'd4
  } apple_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v, input logic [15:0] taps);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) begin
      s = s ^ taps;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the apple respawn entropy source.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [15:0] value_o
);

  logic [15:0] r_lfsr;

  // Advances every cycle regardless of the consumer's state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr, TAPS);
    end
  end

  assign value_o = r_lfsr;

endmodule

// File: rtl/apple_event_gen.sv
// Apple collision event producer: checks the head on move ticks, shapes apple_colline, respawns the apple.
// Optional macro APPLE_HIT_CNT_EN adds hit_count_o, a saturating (0..99) hit counter.
module apple_event_gen
  import snake_pkg::*;
#(
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter int          X_W       = snake_pkg::X_W,
  parameter int          Y_W       = snake_pkg::Y_W,
  parameter int          PULSE_LEN = 4,
  parameter int          MAX_TRIES = 16,
  parameter int          APPLE_X0  = 20,
  parameter int          APPLE_Y0  = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           game_active_i,
  input  logic           move_tick_i,
  input  logic [X_W-1:0] head_x_i,
  input  logic [Y_W-1:0] head_y_i,
  output logic           apple_colline,
  output logic [X_W-1:0] apple_x_o,
  output logic [Y_W-1:0] apple_y_o,
  output logic           apple_valid_o
`ifdef APPLE_HIT_CNT_EN
  ,
  output logic [6:0]     hit_count_o
`endif
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [X_W:0] GRID_W_L = (X_W + 1)'(GRID_W);
  localparam logic [Y_W:0] GRID_H_L = (Y_W + 1)'(GRID_H);

  apple_state_t   r_state, w_state_nxt;
  logic [X_W-1:0] r_head_x, w_head_x_nxt, r_pend_x, w_pend_x_nxt, r_apple_x, w_apple_x_nxt;
  logic [Y_W-1:0] r_head_y, w_head_y_nxt, r_pend_y, w_pend_y_nxt, r_apple_y, w_apple_y_nxt;
  logic           r_pend, w_pend_nxt, r_colline, w_colline_nxt, r_valid, w_valid_nxt;
  logic [CNT_W-1:0] r_pulse_cnt, w_pulse_cnt_nxt;
  logic [TRY_W-1:0] r_tries, w_tries_nxt;

  logic [15:0]    w_lfsr;
  logic [X_W-1:0] w_cand_x, w_fb_x;
  logic [Y_W-1:0] w_cand_y;
  logic           w_cand_ok, w_hit, w_strobe, w_unused_lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .value_o (w_lfsr)
  );

  assign w_cand_x      = w_lfsr[X_W-1:0];
  assign w_cand_y      = w_lfsr[X_W+Y_W-1:X_W];
  assign w_unused_lfsr = ^w_lfsr[15:X_W+Y_W];
  assign w_strobe      = move_tick_i && game_active_i;
  assign w_hit         = (r_head_x == r_apple_x) && (r_head_y == r_apple_y);
  // A candidate on the head cell would be eaten instantly, so it is rejected.
  assign w_cand_ok     = ({1'b0, w_cand_x} < GRID_W_L) && ({1'b0, w_cand_y} < GRID_H_L) &&
                         !((w_cand_x == r_head_x) && (w_cand_y == r_head_y));
  assign w_fb_x        = (r_head_x == X_W'(GRID_W - 1)) ? {X_W{1'b0}} : (r_head_x + X_W'(1));

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state_nxt     = r_state;
    w_head_x_nxt    = r_head_x;
    w_head_y_nxt    = r_head_y;
    w_pend_nxt      = r_pend;
    w_pend_x_nxt    = r_pend_x;
    w_pend_y_nxt    = r_pend_y;
    w_apple_x_nxt   = r_apple_x;
    w_apple_y_nxt   = r_apple_y;
    w_colline_nxt   = r_colline;
    w_valid_nxt     = r_valid;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_tries_nxt     = r_tries;
    if (!game_active_i) begin
      w_state_nxt   = ST_IDLE;
      w_colline_nxt = 1'b0;
      w_pend_nxt    = 1'b0;
      w_valid_nxt   = 1'b1;
    end else begin
      if (w_strobe && (r_state != ST_IDLE)) begin
        w_pend_nxt   = 1'b1;
        w_pend_x_nxt = head_x_i;
        w_pend_y_nxt = head_y_i;
      end else begin
        w_pend_nxt = r_pend;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            w_head_x_nxt = head_x_i;
            w_head_y_nxt = head_y_i;
            w_pend_nxt   = 1'b0;
            w_state_nxt  = ST_CHECK;
          end else if (r_pend) begin
            w_head_x_nxt = r_pend_x;
            w_head_y_nxt = r_pend_y;
            w_pend_nxt   = 1'b0;
            w_state_nxt  = ST_CHECK;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_hit) begin
            w_state_nxt     = ST_PULSE;
            w_colline_nxt   = 1'b1;
            w_pulse_cnt_nxt = CNT_W'(PULSE_LEN - 1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (r_pulse_cnt == {CNT_W{1'b0}}) begin
            w_state_nxt   = ST_GAP;
            w_colline_nxt = 1'b0;
          end else begin
            w_pulse_cnt_nxt = r_pulse_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          w_state_nxt = ST_RESPAWN;
          w_valid_nxt = 1'b0;
          w_tries_nxt = {TRY_W{1'b0}};
        end
        ST_RESPAWN: begin
          if (r_tries == TRY_W'(MAX_TRIES)) begin
            w_apple_x_nxt = w_fb_x;
            w_apple_y_nxt = r_head_y;
            w_valid_nxt   = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else if (w_cand_ok) begin
            w_apple_x_nxt = w_cand_x;
            w_apple_y_nxt = w_cand_y;
            w_valid_nxt   = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_tries_nxt = r_tries + TRY_W'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_colline_nxt = 1'b0;
          w_valid_nxt   = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_head_x    <= {X_W{1'b0}};
      r_head_y    <= {Y_W{1'b0}};
      r_pend      <= 1'b0;
      r_pend_x    <= {X_W{1'b0}};
      r_pend_y    <= {Y_W{1'b0}};
      r_apple_x   <= X_W'(APPLE_X0);
      r_apple_y   <= Y_W'(APPLE_Y0);
      r_colline   <= 1'b0;
      r_valid     <= 1'b1;
      r_pulse_cnt <= {CNT_W{1'b0}};
      r_tries     <= {TRY_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_head_x    <= w_head_x_nxt;
      r_head_y    <= w_head_y_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_x    <= w_pend_x_nxt;
      r_pend_y    <= w_pend_y_nxt;
      r_apple_x   <= w_apple_x_nxt;
      r_apple_y   <= w_apple_y_nxt;
      r_colline   <= w_colline_nxt;
      r_valid     <= w_valid_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_tries     <= w_tries_nxt;
    end
  end

  assign apple_colline = r_colline;
  assign apple_x_o     = r_apple_x;
  assign apple_y_o     = r_apple_y;
  assign apple_valid_o = r_valid;

`ifdef APPLE_HIT_CNT_EN
  logic [6:0] r_hit_cnt;
  logic       r_active_d;

  // Debug score: cleared at the start of each game, saturates at the two-digit display limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hit_cnt  <= 7'd0;
      r_active_d <= 1'b0;
    end else begin
      r_active_d <= game_active_i;
      if (game_active_i && !r_active_d) begin
        r_hit_cnt <= 7'd0;
      end else if (game_active_i && (r_state == ST_CHECK) && w_hit && (r_hit_cnt != 7'd99)) begin
        r_hit_cnt <= r_hit_cnt + 7'd1;
      end else begin
        r_hit_cnt <= r_hit_cnt;
      end
    end
  end

  assign hit_count_o = r_hit_cnt;
`endif

endmodule
